period_meter: RTL and testbench

- Measuring counterpart of the millisecond period generator: instead of producing a pulse every `period` ms, it receives a pulse train and reports the elapsed whole milliseconds between consecutive rising edges.
- Sits behind board inputs (button/sensor lines) or loops back a generator output for self-check.
- Feeds display and game logic with a measured period plus a one-cycle valid strobe.

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/period_meter_edge_sync.sv | 30 +++
 rtl/period_meter.sv | 132 +++++++++++++
 tb/tb_period_meter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared timing definitions for the millisecond generator / meter pair.
package period_meter_pkg;

  // Board clock is 100 MHz, so one millisecond is 100000 cycles.
  localparam int CLKS_PER_MS_DEFAULT = 100000;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    OVF     = 2'd2
  } state_e;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Two-flop synchroniser with a history flop and rising-edge detect.
// Usable for any asynchronous level input (buttons, sensors).
module period_meter_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronise d_i into the clk domain and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Rising edge: synchronised level is high and was low one cycle ago.
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/period_meter.sv
// Measures whole milliseconds between consecutive rising edges of sig_in.
//
// Handshake: valid is a one-cycle strobe; period_ms is stable from the
// cycle valid is high until the next valid (or clear/reset). There is no
// back-pressure: a consumer must capture period_ms while valid is high.
//
// Timing: the prescaler and ms counter restart on each captured edge. If a
// rise and a tick land on the same cycle the rise wins, so the reported
// value is the number of completed ticks strictly before the edge.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT,
  parameter int MS_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig_in,
  input  logic                clear,
  output logic [MS_WIDTH-1:0] period_ms,
  output logic                valid,
  output logic                overflow,
  output logic                busy,
  output state_e              state_dbg
);

  localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [MS_WIDTH-1:0] MS_MAX  = '1;

  logic                rise;
  logic                tick;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [MS_WIDTH-1:0] ms_q, ms_d;
  logic [MS_WIDTH-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic                busy_q;

  period_meter_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sig_in),
    .rise_o (rise)
  );

  assign tick = (pre_q == PRE_MAX);

  // Next-state logic for the FSM, prescaler, ms counter and outputs.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    ms_d     = ms_q;
    period_d = period_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    if (clear) begin
      // Re-arm: drop any measurement in progress, including a same-cycle edge.
      state_d  = IDLE;
      pre_d    = '0;
      ms_d     = '0;
      period_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pre_d = '0;
          ms_d  = '0;
          if (rise) state_d = MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period_d = ms_q;
            valid_d  = 1'b1;
            ovf_d    = 1'b0;
            pre_d    = '0;
            ms_d     = '0;
          end else if (tick) begin
            pre_d = '0;
            if (ms_q == MS_MAX) begin
              // Counter saturated: flag it and wait for an edge to re-arm.
              ovf_d   = 1'b1;
              state_d = OVF;
            end else begin
              ms_d = ms_q + 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        OVF: begin
          if (rise) begin
            state_d = MEASURE;
            pre_d   = '0;
            ms_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      ms_q     <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d == MEASURE);
    end
  end

  assign period_ms = period_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomised bench for period_meter with a queue-based scoreboard.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int C = 10;
  localparam int W = 4;
  localparam int MS_LIMIT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] period_ms;
  logic         valid;
  logic         overflow;
  logic         busy;
  state_e       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: edge bookkeeping in driver-cycle units.
  bit armed = 1'b0;
  bit exp_ovf = 1'b0;
  int last_edge = 0;
  int cyc = 0;

  period_meter #(.CLKS_PER_MS(C), .MS_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .clear     (clear),
    .period_ms (period_ms),
    .valid     (valid),
    .overflow  (overflow),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reported period = completed ms ticks strictly before the edge;
  // more than MS_LIMIT ticks means overflow instead of a measurement.
  task automatic model_edge();
    int p;
    int n;
    if (!armed) begin
      armed = 1'b1;
    end else begin
      p = cyc - last_edge;
      n = (p - 1) / C;
      if (n <= MS_LIMIT) begin
        exp_q.push_back(W'(n));
        exp_ovf = 1'b0;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    last_edge = cyc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 3-cycle-wide pulse; the next edge follows gap cycles later.
  task automatic send_edge(input int gap);
    sig_in = 1'b1;
    model_edge();
    idle(3);
    check("busy_after_edge", busy, 1);
    check("overflow_after_edge", overflow, exp_ovf);
    sig_in = 1'b0;
    idle(gap - 3);
  endtask

  // Pulse whose synchronised rise coincides with clear.
  task automatic clear_with_rise(input int gap);
    sig_in = 1'b1;
    idle(2);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    armed = 1'b0;
    exp_ovf = 1'b0;
    check("clear_period", period_ms, 0);
    check("clear_valid", valid, 0);
    check("clear_state", state_dbg, IDLE);
    check("clear_busy", busy, 0);
    check("clear_overflow", overflow, 0);
    sig_in = 1'b0;
    idle(gap - 3);
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_period", period_ms, 0);
    check("rst_valid", valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    armed = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk) rst = 1'b0;
    idle(1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        check("valid_not_back_to_back", prev_valid, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=period %0d required=no valid", period_ms);
        end else begin
          check("period_ms", period_ms, exp_q.pop_front());
          check("overflow_on_valid", overflow, 0);
        end
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    idle(3);
    check("reset_period", period_ms, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    @(negedge clk) rst = 1'b0;
    idle(1);

    // Idle input: nothing happens.
    idle(50);
    check("idle_period", period_ms, 0);
    check("idle_busy", busy, 0);
    check("idle_overflow", overflow, 0);
    check("idle_state", state_dbg, IDLE);

    // 35-cycle period, then 30-cycle period (rise beats tick).
    repeat (5) send_edge(35);
    repeat (4) send_edge(30);

    // Overflow, re-arm, then a short valid measurement.
    send_edge(170);
    check("ovf_set", overflow, 1);
    check("ovf_state", state_dbg, OVF);
    check("ovf_busy", busy, 0);
    send_edge(25);
    send_edge(30);

    // clear coinciding with a rise in MEASURE.
    clear_with_rise(20);
    send_edge(20);
    send_edge(15);
    send_edge(15);
    reset_mid();
    send_edge(25);
    send_edge(25);

    // Randomised periods, including some around the overflow boundary.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0)
        gap = $urandom_range(150, 220);
      else
        gap = $urandom_range(5, 80);
      send_edge(gap);
    end
    send_edge(40);

    idle(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
